// File: rtl/sram_pingpong_ctrl_if.sv
// Producer stream, consumer stream and SRAM bank signals of the ping-pong tile controller.
interface sram_pingpong_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  logic [1:0]            buf_full;
  logic                  sram_wen;
  logic                  sram_rwen;
  logic [ADDR_WIDTH-1:0] sram_rwadr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic                  sram_ren;
  logic [ADDR_WIDTH-1:0] sram_radr;
  logic [DATA_WIDTH-1:0] sram_rdata;

  // Controller side
  modport slave (
    input  in_valid, in_data, out_ready, sram_rdata,
    output in_ready, out_valid, out_data, out_last, buf_full,
           sram_wen, sram_rwen, sram_rwadr, sram_wdata, sram_ren, sram_radr
  );

  // Producer / consumer / SRAM side
  modport master (
    output in_valid, in_data, out_ready, sram_rdata,
    input  in_ready, out_valid, out_data, out_last, buf_full,
           sram_wen, sram_rwen, sram_rwadr, sram_wdata, sram_ren, sram_radr
  );
endinterface

// File: rtl/sram_pingpong_ctrl.sv
// Double-buffer tile controller: the writer fills one SRAM half while the
// reader drains the other through a 2-entry FIFO that hides the read latency.
module sram_pingpong_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned TILE_DEPTH = 2048
) (
  input logic                 clk,
  input logic                 rst,
  sram_pingpong_ctrl_if.slave bus
);
  localparam int unsigned OFS_W = ADDR_WIDTH - 1;
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(TILE_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_buf_full;
  logic                  r_wr_buf;
  logic [OFS_W-1:0]      r_wr_cnt;
  logic                  r_rd_buf;
  logic [OFS_W-1:0]      r_rd_cnt;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic [1:0]            r_fifo_cnt;
  logic                  r_fifo_wptr;
  logic                  r_fifo_rptr;

  logic                  w_in_ready;
  logic                  w_wr_hs;
  logic                  w_wr_last;
  logic                  w_out_valid;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_release;
  logic [1:0]            w_full_set;
  logic [1:0]            w_full_clr;

  // Write-side handshake and tile-completion detection
  always_comb begin
    w_in_ready = ~r_buf_full[r_wr_buf];
    w_wr_hs    = bus.in_valid & w_in_ready;
    w_wr_last  = w_wr_hs & (r_wr_cnt == LAST_OFS);
    w_full_set = {w_wr_last & r_wr_buf, w_wr_last & ~r_wr_buf};
    w_full_clr = {w_release & r_rd_buf, w_release & ~r_rd_buf};
  end

  // Read-side occupancy: FIFO entries plus the word still inside the SRAM
  always_comb begin
    w_out_valid = (r_fifo_cnt != 2'd0);
    w_pop       = w_out_valid & bus.out_ready;
    w_occ       = 3'(r_fifo_cnt) + 3'(r_inflight) - 3'(w_pop);
  end

  // Reader FSM next state, issue and release decisions
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_buf_full[r_rd_buf]) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_issue = (w_occ < 3'd2);
        if (w_issue && (r_rd_cnt == LAST_OFS)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && r_fifo_last[r_fifo_rptr]) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reader FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Writer half select and offset counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_buf <= 1'b0;
      r_wr_cnt <= '0;
    end else if (w_wr_hs) begin
      if (w_wr_last) begin
        r_wr_buf <= ~r_wr_buf;
        r_wr_cnt <= '0;
      end else begin
        r_wr_cnt <= r_wr_cnt + OFS_W'(1);
      end
    end
  end

  // Reader half select and offset counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_buf <= 1'b0;
      r_rd_cnt <= '0;
    end else if (w_release) begin
      r_rd_buf <= ~r_rd_buf;
      r_rd_cnt <= '0;
    end else if (w_issue) begin
      r_rd_cnt <= r_rd_cnt + OFS_W'(1);
    end
  end

  // Per-half full flags; a fill and a release of different halves may coincide
  always_ff @(posedge clk) begin
    if (rst) r_buf_full <= 2'b00;
    else     r_buf_full <= (r_buf_full | w_full_set) & ~w_full_clr;
  end

  // In-flight read tracking and FIFO pointers/count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_cnt      <= 2'd0;
      r_fifo_wptr     <= 1'b0;
      r_fifo_rptr     <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & (r_rd_cnt == LAST_OFS);
      r_fifo_cnt      <= r_fifo_cnt + 2'(r_inflight) - 2'(w_pop);
      if (r_inflight) r_fifo_wptr <= ~r_fifo_wptr;
      if (w_pop)      r_fifo_rptr <= ~r_fifo_rptr;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset needed
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo_data[r_fifo_wptr] <= bus.sram_rdata;
      r_fifo_last[r_fifo_wptr] <= r_inflight_last;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.sram_wen   = w_wr_hs;
  assign bus.sram_rwen  = 1'b0;
  assign bus.sram_rwadr = {r_wr_buf, r_wr_cnt};
  assign bus.sram_wdata = bus.in_data;
  assign bus.sram_ren   = w_issue;
  assign bus.sram_radr  = {r_rd_buf, r_rd_cnt};
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_fifo_data[r_fifo_rptr];
  assign bus.out_last   = w_out_valid & r_fifo_last[r_fifo_rptr];
  assign bus.buf_full   = r_buf_full;
endmodule
